// File: rtl/awb_gain.sv
// White-balance gain stage: per-channel Q4.8 gain with rounding/saturation, 2-cycle latency,
// frame-synchronous gain update and per-frame channel sums. AWB_AUTO_EN adds a gray-world gain solver.
module awb_gain #(
    parameter int GAIN_W = 12,
    parameter int SUM_W  = 26
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [7:0]        in_R,
    input  logic [7:0]        in_G,
    input  logic [7:0]        in_B,
    input  logic [GAIN_W-1:0] cfg_r_gain,
    input  logic [GAIN_W-1:0] cfg_g_gain,
    input  logic [GAIN_W-1:0] cfg_b_gain,
`ifdef AWB_AUTO_EN
    input  logic              cfg_auto,
    output logic              awb_busy,
`endif
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [7:0]        out_R,
    output logic [7:0]        out_G,
    output logic [7:0]        out_B,
    output logic [SUM_W-1:0]  stat_sum_r,
    output logic [SUM_W-1:0]  stat_sum_g,
    output logic [SUM_W-1:0]  stat_sum_b,
    output logic              stat_valid
);
    localparam int P_W = GAIN_W + 9;
    localparam int Q_W = P_W - 8;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(256);

    logic [2:0][7:0]        pix_in;
    logic [2:0][7:0]        out_pix;
    logic [2:0][SUM_W-1:0]  stat_pix;
    logic [2:0][GAIN_W-1:0] act_gain;
    logic [2:0][GAIN_W-1:0] pend_gain;
    logic [2:0][GAIN_W-1:0] eff_gain;

    logic vsync_d, frame_active, stat_valid_reg;
    logic vs1, hs1, den1, vs2, hs2, den2;
    logic frame_start, frame_end, acc_en;

    assign pix_in      = {in_B, in_G, in_R};
    assign frame_start = in_vsync & ~vsync_d;
    assign frame_end   = ~in_vsync & vsync_d;
    // Counting only inside a frame seen from its start keeps a frame cut by reset out of the stats.
    assign acc_en      = in_den & in_vsync & (frame_active | frame_start);
    assign eff_gain    = frame_start ? pend_gain : act_gain;

    // vsync_d resets high so a reset released mid-frame is not mistaken for a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d        <= 1'b1;
            frame_active   <= 1'b0;
            stat_valid_reg <= 1'b0;
            act_gain       <= {3{UNITY}};
            {vs1, hs1, den1, vs2, hs2, den2} <= '0;
        end else begin
            vsync_d        <= in_vsync;
            stat_valid_reg <= frame_end & frame_active;
            if (frame_start) begin
                frame_active <= 1'b1;
                act_gain     <= pend_gain;
            end else if (frame_end) begin
                frame_active <= 1'b0;
            end
            {vs1, hs1, den1} <= {in_vsync, in_hsync, in_den};
            {vs2, hs2, den2} <= {vs1, hs1, den1};
        end
    end

`ifdef AWB_AUTO_EN
    logic [2:0][SUM_W-1:0] sum_now;
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [Q_W-1:0]   p_reg;
            logic [7:0]       out_reg;
            logic [SUM_W-1:0] sum_reg, stat_reg;
            logic [SUM_W:0]   sum_ext;

            assign sum_ext      = (SUM_W+1)'(sum_reg) + (SUM_W+1)'(pix_in[gi]);
            assign out_pix[gi]  = out_reg;
            assign stat_pix[gi] = stat_reg;
`ifdef AWB_AUTO_EN
            assign sum_now[gi]  = sum_reg;
`endif

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p_reg    <= '0;
                    out_reg  <= '0;
                    sum_reg  <= '0;
                    stat_reg <= '0;
                end else begin
                    p_reg <= Q_W'((P_W'(pix_in[gi]) * P_W'(eff_gain[gi]) + P_W'(128)) >> 8);
                    if (!den1)
                        out_reg <= '0;
                    else if (|p_reg[Q_W-1:8])
                        out_reg <= 8'hFF;
                    else
                        out_reg <= p_reg[7:0];
                    if (frame_end) begin
                        if (frame_active)
                            stat_reg <= sum_reg;
                        sum_reg <= '0;
                    end else if (acc_en) begin
                        sum_reg <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
                    end
                end
            end
        end
    endgenerate

`ifdef AWB_AUTO_EN
    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, DONE} state_t;
    localparam int DV_W  = SUM_W + 8;
    localparam int CNT_W = $clog2(DV_W);

    state_t             state;
    logic               busy_reg;
    logic [DV_W-1:0]    dvd_reg;
    logic [SUM_W-1:0]   rem_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [GAIN_W-1:0]  auto_r, auto_b, new_r, new_b;
    logic [SUM_W-1:0]   divisor;
    logic [SUM_W:0]     rem_shift;
    logic               ge, last;
    logic [DV_W-1:0]    quot;
    logic [GAIN_W-1:0]  q_sat;

    assign divisor   = (state == DIV_B) ? stat_pix[2] : stat_pix[0];
    assign rem_shift = {rem_reg, dvd_reg[DV_W-1]};
    assign ge        = rem_shift >= {1'b0, divisor};
    assign last      = cnt_reg == CNT_W'(DV_W - 1);
    // Quotient bits shift into the vacated low end of the dividend register.
    assign quot      = {dvd_reg[DV_W-2:0], ge};
    assign q_sat     = (|quot[DV_W-1:GAIN_W]) ? {GAIN_W{1'b1}} : quot[GAIN_W-1:0];
    assign pend_gain = cfg_auto ? {auto_b, UNITY, auto_r} : {cfg_b_gain, cfg_g_gain, cfg_r_gain};
    assign awb_busy  = busy_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            dvd_reg  <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            auto_r   <= UNITY;
            auto_b   <= UNITY;
            new_r    <= UNITY;
            new_b    <= UNITY;
        end else if (frame_start && state != IDLE) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_end && frame_active && cfg_auto) begin
                    state    <= DIV_R;
                    busy_reg <= 1'b1;
                    dvd_reg  <= {sum_now[1], 8'd0};
                    rem_reg  <= '0;
                    cnt_reg  <= '0;
                end
                DIV_R, DIV_B: begin
                    dvd_reg <= quot;
                    rem_reg <= ge ? SUM_W'(rem_shift - {1'b0, divisor}) : rem_shift[SUM_W-1:0];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last) begin
                        cnt_reg <= '0;
                        rem_reg <= '0;
                        if (state == DIV_R) begin
                            new_r   <= (divisor == '0) ? auto_r : q_sat;
                            dvd_reg <= {stat_pix[1], 8'd0};
                            state   <= DIV_B;
                        end else begin
                            new_b <= (divisor == '0) ? auto_b : q_sat;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    auto_r   <= new_r;
                    auto_b   <= new_b;
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign pend_gain = {cfg_b_gain, cfg_g_gain, cfg_r_gain};
`endif

    assign {out_B, out_G, out_R} = out_pix;
    assign stat_sum_r = stat_pix[0];
    assign stat_sum_g = stat_pix[1];
    assign stat_sum_b = stat_pix[2];
    assign out_vsync  = vs2;
    assign out_hsync  = hs2;
    assign out_den    = den2;
    assign stat_valid = stat_valid_reg;
endmodule
